pixel_word_packer: RTL

//  Upstream feeder of the HPS-readable 32-bit data PIO. Accepts 8-bit filtered pixels from the

---
 rtl/pixel_word_packer_pkg.sv | 34 +++
 rtl/pixel_word_packer_sync_fifo_sa.sv | 90 +++++++++
 rtl/pixel_word_packer.sv | 134 +++++++++++++
 3 files changed

// File: rtl/pixel_word_packer_pkg.sv
// ---------------------------------------------------------------------------
// pixel_word_packer_pkg
//   Shared geometry for the pixel packer and its word FIFO: pixel width,
//   lanes per word, word width, and a helper that fills unused lanes of a
//   frame-final partial word with the pad byte.
//   No ports (package).
// ---------------------------------------------------------------------------
package pixel_word_packer_pkg;

    localparam int PIX_W  = 8;
    localparam int LANES  = 4;
    localparam int WORD_W = 32;
    localparam int LANE_W = $clog2(LANES);
    // Stored FIFO entry: packed word plus one "contains pix_last" tag bit.
    localparam int ENTRY_W = WORD_W + 1;

    // Every lane above last_lane is overwritten with pad; lanes up to and
    // including last_lane keep the pixels already packed into them.
    function automatic logic [WORD_W-1:0] pad_lanes(
        input logic [WORD_W-1:0] word,
        input logic [LANE_W-1:0] last_lane,
        input logic [PIX_W-1:0]  pad
    );
        logic [WORD_W-1:0] r;
        r = word;
        for (int i = 0; i < LANES; i++) begin
            if (i > int'(last_lane)) begin
                r[i*PIX_W +: PIX_W] = pad;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pixel_word_packer_sync_fifo_sa.sv
// ---------------------------------------------------------------------------
// sync_fifo_sa
//   Show-ahead synchronous FIFO: the oldest entry is always visible on head
//   without a read strobe; pop discards it. Full/empty/level are registered
//   so downstream ready logic has no combinational path from push/pop.
//   Ports:
//     clk, reset   clock and synchronous active-high reset (pointers/level)
//     push, din    write strobe and data; ignored while full
//     pop          discard head; ignored while empty
//     head         current oldest entry (undefined content when empty)
//     level        number of stored entries, 0..DEPTH
//     full, empty  registered status flags
// ---------------------------------------------------------------------------
module sync_fifo_sa #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   level_q,  level_d;
    logic             full_q,   full_d;
    logic             empty_q,  empty_d;
    logic             do_push,  do_pop;

    always_comb begin
        do_push  = push & ~full_q;
        do_pop   = pop  & ~empty_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        // Pointers wrap naturally because DEPTH is a power of two.
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        full_d  = (level_d == (PTR_W+1)'(DEPTH));
        empty_d = (level_d == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign level = level_q;
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/pixel_word_packer.sv
// ---------------------------------------------------------------------------
// pixel_word_packer
//   Packs 8-bit filtered pixels four per 32-bit word (pixel 0 in [7:0]),
//   buffers the words in a show-ahead FIFO and exposes the head word to the
//   HPS data PIO. The HPS pops one word per change of the rd_toggle level.
//   Ports:
//     clk, reset    single clock, synchronous active-high reset
//     pix_valid     pixel present on pix_data
//     pix_data      8-bit pixel
//     pix_last      last pixel of a frame (meaningful only with pix_valid)
//     pix_ready     pixel accepted when pix_valid && pix_ready (= not full)
//     rd_toggle     HPS pop request level; every change pops one word
//     clr_status    one-cycle pulse clearing the sticky flags
//     data_out      FIFO head word, 32'h0 when empty
//     word_avail    FIFO non-empty
//     fifo_level    words currently stored
//     frame_done    sticky: word holding pix_last has been popped
//     overflow      sticky: reserved, never set (pix_ready prevents loss)
//     underflow     sticky: pop requested while FIFO empty
// ---------------------------------------------------------------------------
module pixel_word_packer
    import pixel_word_packer_pkg::*;
#(
    parameter int               FIFO_DEPTH = 16,
    parameter logic [PIX_W-1:0] PAD_BYTE   = 8'h00
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        pix_valid,
    input  logic [PIX_W-1:0]            pix_data,
    input  logic                        pix_last,
    output logic                        pix_ready,
    input  logic                        rd_toggle,
    input  logic                        clr_status,
    output logic [WORD_W-1:0]           data_out,
    output logic                        word_avail,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        frame_done,
    output logic                        overflow,
    output logic                        underflow
);

    logic [LANE_W-1:0]  lane_q,       lane_d;
    logic [WORD_W-1:0]  shreg_q,      shreg_d;
    logic               rd_toggle_q,  rd_toggle_d;
    logic               frame_done_q, frame_done_d;
    logic               overflow_q,   overflow_d;
    logic               underflow_q,  underflow_d;

    logic               accept;
    logic               commit;
    logic               pop_req;
    logic               pop;
    logic [WORD_W-1:0]  merged;
    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] head;
    logic               fifo_full;
    logic               fifo_empty;

    always_comb begin
        // Ready depends only on the registered full flag, never on pix_valid.
        accept = pix_valid & ~fifo_full;

        merged = shreg_q;
        merged[lane_q*PIX_W +: PIX_W] = pix_data;

        commit     = accept & ((lane_q == LANE_W'(LANES-1)) | pix_last);
        push_entry = {pix_last, pad_lanes(merged, lane_q, PAD_BYTE)};

        lane_d  = lane_q;
        shreg_d = shreg_q;
        if (accept) begin
            if (commit) begin
                lane_d  = '0;
                shreg_d = '0;
            end else begin
                lane_d  = lane_q + 1'b1;
                shreg_d = merged;
            end
        end

        // A level change since last cycle is one pop request.
        rd_toggle_d = rd_toggle;
        pop_req     = rd_toggle ^ rd_toggle_q;
        pop         = pop_req & ~fifo_empty;

        // Set terms are OR-ed after the clear so a same-cycle set wins.
        frame_done_d = (frame_done_q & ~clr_status) | (pop & head[WORD_W]);
        underflow_d  = (underflow_q  & ~clr_status) | (pop_req & fifo_empty);
        overflow_d   =  overflow_q   & ~clr_status;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lane_q       <= '0;
            shreg_q      <= '0;
            // Track the current level so leaving reset is not seen as a pop.
            rd_toggle_q  <= rd_toggle;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            lane_q       <= lane_d;
            shreg_q      <= shreg_d;
            rd_toggle_q  <= rd_toggle_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    sync_fifo_sa #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (commit),
        .din   (push_entry),
        .pop   (pop),
        .head  (head),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign pix_ready  = ~fifo_full;
    assign data_out   = fifo_empty ? '0 : head[WORD_W-1:0];
    assign word_avail = ~fifo_empty;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;

endmodule
